// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch/decode queue slice.
// One entry is a fetched {PC, instruction} pair.
package fd_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_entry_t;

endpackage

// File: rtl/fd_queue_mem.sv
// Entry storage for the fetch/decode queue: one write port, two async read
// ports (head and head+1). Contents are never cleared; validity lives in the pointers.
module fd_queue_mem
    import fd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  fd_entry_t       i_wdata,
    input  logic [AW-1:0]   i_head_addr,
    input  logic [AW-1:0]   i_next_addr,
    output fd_entry_t       o_head,
    output fd_entry_t       o_next
);

    fd_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_head = r_mem[i_head_addr];
    assign o_next = r_mem[i_next_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Decoupling queue between fetch and decode. Holds fetched {PC, instr} pairs,
// back-pressures fetch through f_ready and supports redirect flush with an optional kept delay slot.
module fetch_decode_queue
    import fd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_valid,
    input  logic [31:0]   f_pc,
    input  logic [31:0]   f_instr,
    output logic          f_ready,
    output logic          d_valid,
    output logic [31:0]   d_pc,
    output logic [31:0]   d_instr,
    input  logic          d_ready,
    input  logic          flush,
    input  logic          flush_keep,
    output logic [AW:0]   count
);

    // Handshake: a pair moves on a side only in a cycle where its valid and
    // ready are both high at the rising edge; f_ready never looks at d_ready.
    localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_TWO  = (AW+1)'(2);
    localparam logic [AW-1:0] P_ONE  = AW'(1);
    localparam logic [AW-1:0] P_TWO  = AW'(2);

    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [AW:0]   r_count;

    logic          w_push, w_pop, w_we;
    logic          w_keep_head, w_keep_next, w_keep_push;
    logic [AW-1:0] w_rd_next, w_wr_next;
    logic [AW:0]   w_count_next;
    fd_entry_t     w_head, w_next_unused;

    assign f_ready = (r_count != C_FULL);
    assign d_valid = (r_count != '0);
    assign w_push  = f_valid & f_ready;
    assign w_pop   = d_valid & d_ready;

    // Oldest survivor of a keep-flush: unpopped head, else second entry, else the incoming pair.
    assign w_keep_head = d_valid & ~w_pop;
    assign w_keep_next = w_pop & (r_count >= C_TWO);
    assign w_keep_push = ~w_keep_head & ~w_keep_next & w_push;

    assign w_we = w_push & (~flush | (flush_keep & w_keep_push));

    always_comb begin
        w_rd_next    = r_rd_ptr;
        w_wr_next    = r_wr_ptr;
        w_count_next = r_count;
        if (flush) begin
            if (flush_keep && w_keep_head) begin
                w_wr_next    = r_rd_ptr + P_ONE;
                w_count_next = (AW+1)'(1);
            end else if (flush_keep && w_keep_next) begin
                w_rd_next    = r_rd_ptr + P_ONE;
                w_wr_next    = r_rd_ptr + P_TWO;
                w_count_next = (AW+1)'(1);
            end else if (flush_keep && w_keep_push) begin
                w_rd_next    = r_wr_ptr;
                w_wr_next    = r_wr_ptr + P_ONE;
                w_count_next = (AW+1)'(1);
            end else begin
                w_rd_next    = r_wr_ptr;
                w_count_next = '0;
            end
        end else begin
            if (w_push) w_wr_next = r_wr_ptr + P_ONE;
            if (w_pop)  w_rd_next = r_rd_ptr + P_ONE;
            if (w_push && !w_pop)      w_count_next = r_count + (AW+1)'(1);
            else if (w_pop && !w_push) w_count_next = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= w_wr_next;
            r_count  <= w_count_next;
        end
    end

    // The head+1 port is where a kept delay slot sits; advancing rd_ptr onto it is enough.
    fd_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk         (clk),
        .i_we        (w_we),
        .i_waddr     (r_wr_ptr),
        .i_wdata     ({f_pc, f_instr}),
        .i_head_addr (r_rd_ptr),
        .i_next_addr (r_rd_ptr + P_ONE),
        .o_head      (w_head),
        .o_next      (w_next_unused)
    );

    assign d_pc    = d_valid ? w_head.pc    : 32'h0;
    assign d_instr = d_valid ? w_head.instr : NOP_INSTR;
    assign count   = r_count;

endmodule
